// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - raster timing constants and shared types for the VGA scan-out engine
package vga_pkg;
  localparam int H_VISIBLE     = 1280;
  localparam int H_FP          = 48;
  localparam int H_SYNC        = 112;
  localparam int H_TOTAL       = 1688;
  localparam int V_VISIBLE     = 1024;
  localparam int V_FP          = 1;
  localparam int V_SYNC        = 3;
  localparam int V_TOTAL       = 1066;
  localparam int LISP_WIDTH    = 768;
  localparam int WORDS_PER_ROW = 24;
  localparam int ADDR_W        = 15;

  typedef logic [10:0]       hcount_t;
  typedef logic [10:0]       vcount_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [4:0]        words_t;

  function automatic vcount_t next_line(input vcount_t v);
    return (v == vcount_t'(V_TOTAL - 1)) ? '0 : v + 1'b1;
  endfunction
endpackage

// File: rtl/vga_display_ctrl_if.sv
// rtl/vga_display_ctrl_if.sv - video RAM read port between the RAM controller and the scan-out engine
interface vga_display_ctrl_if;
  import vga_pkg::*;

  addr_t       vram_addr;
  logic [31:0] vram_data;
  logic        vram_req;
  logic        vram_ready;

  modport master (output vram_addr, output vram_req, input vram_data, input vram_ready);
  modport slave  (input vram_addr, input vram_req, output vram_data, output vram_ready);
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 1280x1024@60 raster counters with combinational sync and visible flags
module vga_timing
  import vga_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  output hcount_t hcount,
  output vcount_t vcount,
  output logic    hsync,
  output logic    vsync,
  output logic    line_visible,
  output logic    visible
);

  // Starting in vertical blanking gives the first visible row time to be prefetched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= vcount_t'(V_VISIBLE);
    end else if (hcount == hcount_t'(H_TOTAL - 1)) begin
      hcount <= '0;
      vcount <= next_line(vcount);
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  assign hsync = (hcount >= hcount_t'(H_VISIBLE + H_FP)) &&
                 (hcount <  hcount_t'(H_VISIBLE + H_FP + H_SYNC));
  assign vsync = (vcount >= vcount_t'(V_VISIBLE + V_FP)) &&
                 (vcount <  vcount_t'(V_VISIBLE + V_FP + V_SYNC));
  assign line_visible = vcount < vcount_t'(V_VISIBLE);
  assign visible      = line_visible && (hcount < hcount_t'(H_VISIBLE));

endmodule

// File: rtl/vga_display_ctrl.sv
// rtl/vga_display_ctrl.sv - monochrome frame-buffer fetch and pixel shifter; VGA_INVERT_EN inverts the Lisp area
module vga_display_ctrl
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  vga_display_ctrl_if.master  vram,
  output logic                vga_red,
  output logic                vga_grn,
  output logic                vga_blu,
  output logic                vga_hsync,
  output logic                vga_vsync
);

  hcount_t     hcount;
  vcount_t     vcount;
  logic        hsync_c, vsync_c, line_visible, visible;
  addr_t       addr_q, row_base, next_row_base;
  logic        req_q, buf_full, prefetch, fetch_go, load, take, pix_bit, lisp, pix;
  words_t      words_left;
  logic [31:0] word_buf, shreg, load_val;
  vcount_t     next_v;

  vga_timing u_timing (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .hsync        (hsync_c),
    .vsync        (vsync_c),
    .line_visible (line_visible),
    .visible      (visible)
  );

  assign next_v        = next_line(vcount);
  assign next_row_base = (next_v == '0) ? '0 : row_base + addr_t'(WORDS_PER_ROW);
  assign prefetch      = (hcount == hcount_t'(H_VISIBLE)) && (next_v < vcount_t'(V_VISIBLE));
  assign fetch_go      = !buf_full && (words_left != '0) && !req_q;
  assign take          = req_q && vram.vram_ready;
  assign load          = (hcount[4:0] == 5'd0) && (hcount < hcount_t'(LISP_WIDTH)) && line_visible;
  assign load_val      = buf_full ? word_buf : '0;

  // Prefetch takes priority over a coincident ready, dropping the returned word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      row_base   <= '0;
      req_q      <= 1'b0;
      words_left <= '0;
      buf_full   <= 1'b0;
      word_buf   <= '0;
    end else if (prefetch) begin
      row_base   <= next_row_base;
      addr_q     <= next_row_base;
      req_q      <= 1'b0;
      words_left <= words_t'(WORDS_PER_ROW);
      buf_full   <= 1'b0;
    end else begin
      if (load) buf_full <= 1'b0;
      if (take) begin
        word_buf   <= vram.vram_data;
        buf_full   <= 1'b1;
        req_q      <= 1'b0;
        addr_q     <= addr_q + 1'b1;
        words_left <= words_left - 1'b1;
      end else if (fetch_go) begin
        req_q <= 1'b1;
      end
    end
  end

  // Bit 0 of a freshly loaded word is emitted in the load cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shreg <= '0;
    else if (load) shreg <= {1'b0, load_val[31:1]};
    else shreg <= {1'b0, shreg[31:1]};
  end

  assign pix_bit = load ? load_val[0] : shreg[0];
  assign lisp    = visible && (hcount < hcount_t'(LISP_WIDTH));
`ifdef VGA_INVERT_EN
  assign pix = lisp && !pix_bit;
`else
  assign pix = lisp && pix_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_red   <= 1'b0;
      vga_grn   <= 1'b0;
      vga_blu   <= 1'b0;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else begin
      vga_red   <= pix;
      vga_grn   <= pix;
      vga_blu   <= pix;
      vga_hsync <= hsync_c;
      vga_vsync <= vsync_c;
    end
  end

  assign vram.vram_addr = addr_q;
  assign vram.vram_req  = req_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// tb/tb_vga_display_ctrl.sv - scoreboard bench: address order, pixel stream, syncs, underflow on row 2
module tb_vga_display_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync;

  always #5 clk = ~clk;

  vga_display_ctrl_if vram ();

  vga_display_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .vram      (vram),
    .vga_red   (vga_red),
    .vga_grn   (vga_grn),
    .vga_blu   (vga_blu),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync)
  );

`ifdef VGA_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  int exp_addr[$];
  bit exp_pix[$];

  int ph, pv, cyc;
  bit mem_pend, first_req_seen, prev_hs, prev_vs;
  int mem_wait, mem_addr_l, hs_len, vs_len, last_hs_rise, hs_rises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, ph, pv);
  endtask

  function automatic logic [31:0] mem_word(input int a);
    if (a == 0) return 32'h0000_0001;
    if (a == 23) return 32'hFFFF_FFFF;
    if (a < 24) return 32'h0;
    return (a * 32'h9E37_79B1) ^ (a << 7);
  endfunction

  // Row 2 is served with 40-cycle latency: word k lands in group 2k, odd groups underflow.
  task automatic push_pixels(input int a);
    logic [31:0] w;
    int row, wi;
    w   = mem_word(a);
    row = a / 24;
    wi  = a % 24;
    if (row != 2 || wi < 12) begin
      for (int j = 0; j < 32; j++) exp_pix.push_back(w[j]);
      if (row == 2)
        for (int j = 0; j < 32; j++) exp_pix.push_back(1'b0);
    end
  endtask

  task automatic step_monitor();
    bit lisp, e;
    lisp = (ph < 768) && (pv < 1024);
    e = 1'b0;
    if (lisp) begin
      check("pix_queue_nonempty", exp_pix.size() > 0, 1);
      if (exp_pix.size() > 0) e = exp_pix.pop_front() ^ INV;
    end
    check("red", vga_red, e);
    check("grn", vga_grn, e);
    check("blu", vga_blu, e);
    check("hsync", vga_hsync, (ph >= 1328) && (ph < 1440));
    check("vsync", vga_vsync, (pv >= 1025) && (pv < 1028));

    if (vga_hsync) hs_len++;
    if (vga_hsync && !prev_hs) begin
      if (last_hs_rise >= 0) check("hsync_period", cyc - last_hs_rise, 1688);
      last_hs_rise = cyc;
      hs_rises++;
    end
    if (!vga_hsync && prev_hs) begin
      check("hsync_width", hs_len, 112);
      hs_len = 0;
    end
    if (vga_vsync) vs_len++;
    if (!vga_vsync && prev_vs) begin
      check("vsync_width", vs_len, 5064);
      vs_len = 0;
    end
    prev_hs = vga_hsync;
    prev_vs = vga_vsync;
  endtask

  task automatic step_mem();
    if (vram.vram_ready) begin
      vram.vram_ready = 1'b0;
    end else if (mem_pend) begin
      check("req_hold", vram.vram_req, 1);
      check("addr_stable", vram.vram_addr, mem_addr_l);
      if (mem_wait <= 1) begin
        vram.vram_data  = mem_word(mem_addr_l);
        vram.vram_ready = 1'b1;
        push_pixels(mem_addr_l);
        mem_pend = 1'b0;
      end else begin
        mem_wait--;
      end
    end else if (vram.vram_req) begin
      if (!first_req_seen) begin
        first_req_seen = 1'b1;
        check("first_req_h", ph, 1281);
        check("first_req_v", pv, 1065);
      end
      check("req_expected", exp_addr.size() > 0, 1);
      if (exp_addr.size() > 0) check("req_addr", vram.vram_addr, exp_addr.pop_front());
      mem_addr_l = int'(vram.vram_addr);
      mem_pend   = 1'b1;
      mem_wait   = (mem_addr_l >= 48 && mem_addr_l < 72) ? 40 : 2;
    end else if (ph == 20 && pv == 0) begin
      // Stray acknowledge with no request outstanding must not disturb the buffer.
      vram.vram_data  = 32'hDEAD_BEEF;
      vram.vram_ready = 1'b1;
    end
  endtask

  initial begin
    reset           = 1'b1;
    vram.vram_ready = 1'b0;
    vram.vram_data  = '0;
    mem_pend        = 1'b0;
    first_req_seen  = 1'b0;
    prev_hs         = 1'b0;
    prev_vs         = 1'b0;
    hs_len          = 0;
    vs_len          = 0;
    hs_rises        = 0;
    last_hs_rise    = -1;
    cyc             = 0;
    ph              = 0;
    pv              = 1024;

    for (int a = 0; a < 48; a++) exp_addr.push_back(a);
    for (int a = 48; a <= 60; a++) exp_addr.push_back(a);
    for (int a = 72; a < 96; a++) exp_addr.push_back(a);

    repeat (3) @(negedge clk);
    check("rst_red", vga_red, 0);
    check("rst_grn", vga_grn, 0);
    check("rst_blu", vga_blu, 0);
    check("rst_hsync", vga_hsync, 0);
    check("rst_vsync", vga_vsync, 0);
    check("rst_req", vram.vram_req, 0);
    check("rst_addr", vram.vram_addr, 0);
    reset = 1'b0;

    while (!(pv == 3 && ph == 800)) begin
      @(negedge clk);
      cyc++;
      step_monitor();
      step_mem();
      if (ph == 1687) begin
        ph = 0;
        pv = (pv == 1065) ? 0 : pv + 1;
      end else begin
        ph++;
      end
    end

    check("first_req_seen", first_req_seen, 1);
    check("addr_queue_left", exp_addr.size(), 0);
    check("pix_queue_left", exp_pix.size(), 0);
    check("hsync_rises", hs_rises, 45);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
